// File: rtl/uart_frame_writer.sv
// Writes received UART bytes into a frame buffer RAM, tracks frame boundaries,
// counts completed frames and aborts a frame when the byte stream stalls.
module uart_frame_writer #(
    parameter int FRAME_BYTES = 30000,
    parameter int ADDR_W      = 15,
    parameter int TIMEOUT_CYC = 1600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              err_clr,
    input  logic [7:0]        rx_data,
    input  logic              rx_flag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              timeout_err
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [TMR_W-1:0]  tmr_q,     tmr_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q,    busy_d;
    logic              fdone_q,   fdone_d;
    logic [7:0]        fcnt_q,    fcnt_d;
    logic              terr_q,    terr_d;
    logic              terr_set;
    logic              start;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tmr_d     = tmr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fdone_d   = 1'b0;
        fcnt_d    = fcnt_q;
        terr_set  = 1'b0;
        start     = 1'b0;

        case (state_q)
            IDLE: begin
                start = rx_flag & enable;
            end
            RECV: begin
                if (!enable) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    tmr_d   = '0;
                end else if (rx_flag) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_data;
                    tmr_d     = '0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = DONE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    // Stalled mid-frame: drop the partial frame so later frames stay aligned
                    terr_set = 1'b1;
                    state_d  = IDLE;
                    addr_d   = '0;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: begin
                fdone_d = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
                state_d = IDLE;
                start   = rx_flag & enable;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                tmr_d   = '0;
            end
        endcase

        // A byte arriving in IDLE or DONE opens a new frame at address 0
        if (start) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = rx_data;
            tmr_d     = '0;
            if (FRAME_BYTES == 1) begin
                state_d = DONE;
                addr_d  = '0;
            end else begin
                state_d = RECV;
                addr_d  = ADDR_W'(1);
            end
        end

        busy_d = (state_d == RECV);
        terr_d = terr_set | (terr_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tmr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
            fcnt_q    <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tmr_q     <= tmr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            fdone_q   <= fdone_d;
            fcnt_q    <= fcnt_d;
            terr_q    <= terr_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = fdone_q;
    assign frame_cnt   = fcnt_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_frame_writer.sv
// Bench for uart_frame_writer with 4-byte frames: table-driven byte vectors,
// a write scoreboard, and hand-written sequences for the multi-cycle cases.
module tb_uart_frame_writer;

    localparam int FB  = 4;
    localparam int AW  = 3;
    localparam int TO  = 1600;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          err_clr;
    logic [7:0]    rx_data;
    logic          rx_flag;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic          timeout_err;

    uart_frame_writer #(
        .FRAME_BYTES(FB),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_flag    (rx_flag),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [AW+7:0] sbq[$];
    logic          prev_last = 1'b0;
    logic [7:0]    exp_cnt = 8'd0;

    typedef struct {
        logic          en;
        logic [7:0]    d;
        int            gap;
        logic          wr;
        logic [AW-1:0] addr;
        logic          busy;
        logic [7:0]    cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard and frame_done model, sampled away from the active edge
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (wr_en === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", wr_addr, wr_data);
            end else begin
                e = sbq.pop_front();
                chk("write_addr", 32'(wr_addr), 32'(e[AW+7:8]));
                chk("write_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
        chk("frame_done_timing", 32'(frame_done), 32'(prev_last));
        prev_last = (wr_en === 1'b1) && (wr_addr == AW'(FB - 1)) && !rst;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic en, input logic [7:0] d, input int gap,
                        input logic expw, input logic [AW-1:0] addr);
        @(negedge clk);
        enable  = en;
        rx_flag = 1'b1;
        rx_data = d;
        if (expw) sbq.push_back({addr, d});
        @(negedge clk);
        rx_flag = 1'b0;
        tick(gap);
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < FB; i++) send(1'b1, base + 8'(i), 1, 1'b1, AW'(i));
        tick(2);
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 154, 1'b1, 3'd0, 1'b1, 8'd0};
        tbl[1]  = '{1'b1, 8'h22, 154, 1'b1, 3'd1, 1'b1, 8'd0};
        tbl[2]  = '{1'b1, 8'h33, 154, 1'b1, 3'd2, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 8'h44, 154, 1'b1, 3'd3, 1'b0, 8'd1};
        tbl[4]  = '{1'b0, 8'hA1, 3,   1'b0, 3'd0, 1'b0, 8'd1};
        tbl[5]  = '{1'b0, 8'hA2, 3,   1'b0, 3'd0, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 8'hA3, 3,   1'b0, 3'd0, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 8'hA4, 3,   1'b0, 3'd0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 8'hA5, 3,   1'b0, 3'd0, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 8'h55, 3,   1'b1, 3'd0, 1'b1, 8'd1};
        tbl[10] = '{1'b1, 8'h66, 3,   1'b1, 3'd1, 1'b1, 8'd1};

        rst = 1'b1; enable = 1'b0; err_clr = 1'b0; rx_data = 8'h00; rx_flag = 1'b0;
        tick(3);
        chk("rst_wr_en",   32'(wr_en),       0);
        chk("rst_wr_addr", 32'(wr_addr),     0);
        chk("rst_wr_data", 32'(wr_data),     0);
        chk("rst_busy",    32'(busy),        0);
        chk("rst_fdone",   32'(frame_done),  0);
        chk("rst_fcnt",    32'(frame_cnt),   0);
        chk("rst_terr",    32'(timeout_err), 0);
        rst = 1'b0;
        tick(2);

        // Basic frame, disabled bytes, and the start of a new frame
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].en, tbl[i].d, tbl[i].gap, tbl[i].wr, tbl[i].addr);
            chk($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i),  32'(frame_cnt), 32'(tbl[i].cnt));
        end
        exp_cnt = 8'd1;

        // Drop enable mid-frame with a byte in the same cycle
        @(negedge clk);
        enable = 1'b0; rx_flag = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        rx_flag = 1'b0;
        chk("dis_busy", 32'(busy),        0);
        chk("dis_terr", 32'(timeout_err), 0);
        enable = 1'b1;
        tick(2);
        send_frame(8'h80);
        chk("dis_next_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Inter-byte timeout
        for (int i = 0; i < 3; i++) send(1'b1, 8'hC0 + 8'(i), 2, 1'b1, AW'(i));
        tick(TO + 2);
        chk("to_terr", 32'(timeout_err), 1);
        chk("to_busy", 32'(busy),        0);
        chk("to_cnt",  32'(frame_cnt),   32'(exp_cnt));
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("clr_terr", 32'(timeout_err), 0);
        send_frame(8'hD0);
        chk("to_next_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Byte in the DONE cycle starts the next frame
        for (int i = 0; i < 3; i++) send(1'b1, 8'hE0 + 8'(i), 2, 1'b1, AW'(i));
        @(negedge clk);
        rx_flag = 1'b1; rx_data = 8'hE3; sbq.push_back({3'd3, 8'hE3});
        @(negedge clk);
        rx_data = 8'hF0; sbq.push_back({3'd0, 8'hF0});
        @(negedge clk);
        rx_flag = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("done_fdone", 32'(frame_done), 1);
        chk("done_wr_en", 32'(wr_en),      1);
        chk("done_addr",  32'(wr_addr),    0);
        chk("done_busy",  32'(busy),       1);
        chk("done_cnt",   32'(frame_cnt),  32'(exp_cnt));
        tick(1);
        for (int i = 1; i < FB; i++) send(1'b1, 8'hF0 + 8'(i), 1, 1'b1, AW'(i));
        tick(2);
        exp_cnt = exp_cnt + 8'd1;
        chk("done_next_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Frame counter wrap
        while (exp_cnt != 8'd255) send_frame(exp_cnt);
        chk("cnt_255", 32'(frame_cnt), 255);
        send_frame(8'h5A);
        chk("cnt_wrap", 32'(frame_cnt), 0);
        send_frame(8'h6A);
        chk("cnt_after_wrap", 32'(frame_cnt), 1);

        // err_clr coinciding with the timeout edge
        @(negedge clk);
        rx_flag = 1'b1; rx_data = 8'h99; sbq.push_back({3'd0, 8'h99});
        @(negedge clk);
        rx_flag = 1'b0;
        tick(TO - 1);
        chk("pre_to_terr", 32'(timeout_err), 0);
        chk("pre_to_busy", 32'(busy),        1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_vs_set_terr", 32'(timeout_err), 1);
        chk("clr_vs_set_busy", 32'(busy),        0);

        // Reset mid-frame at address 2
        send(1'b1, 8'h31, 2, 1'b1, 3'd0);
        send(1'b1, 8'h32, 2, 1'b1, 3'd1);
        @(negedge clk);
        rx_flag = 1'b1; rx_data = 8'h33; sbq.push_back({3'd2, 8'h33});
        @(negedge clk);
        rx_flag = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        chk("mrst_wr_en",   32'(wr_en),       0);
        chk("mrst_wr_addr", 32'(wr_addr),     0);
        chk("mrst_wr_data", 32'(wr_data),     0);
        chk("mrst_busy",    32'(busy),        0);
        chk("mrst_fdone",   32'(frame_done),  0);
        chk("mrst_fcnt",    32'(frame_cnt),   0);
        chk("mrst_terr",    32'(timeout_err), 0);
        tick(2);
        send_frame(8'h40);
        chk("mrst_next_cnt", 32'(frame_cnt), 32'(exp_cnt));

        tick(3);
        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
